// File: rtl/gray_conv_arbiter.sv
// Round-robin arbiter for four requesters sharing one 4-bit binary/Gray converter with a registered result stage.
// Latency: grant is combinational in cycle T and the result is valid from cycle T+1; one result per cycle when out_ready is held high.
// Backpressure: while out_valid & !out_ready the result is held and gnt stays low; a handshake and a new grant may share an edge.
module gray_conv_arbiter (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  req,
    input  logic [15:0] req_data,
    input  logic [3:0]  req_mode,
    output logic [3:0]  gnt,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [3:0]  out_data,
    output logic [1:0]  out_id,
    output logic        out_mode,
    output logic [7:0]  conv_count
);

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    state_t     state;
    logic [1:0] last;
    logic [1:0] sel;
    logic [1:0] idx;
    logic       found;
    logic       handshake;
    logic       can_accept;
    logic [3:0] sel_data;
    logic       sel_mode;
    logic [3:0] conv_data;

    function automatic logic [3:0] bin2gray(input logic [3:0] b);
        logic [3:0] g;
        g[3] = b[3];
        g[2] = b[3] ^ b[2];
        g[1] = b[2] ^ b[1];
        g[0] = b[1] ^ b[0];
        return g;
    endfunction

    function automatic logic [3:0] gray2bin(input logic [3:0] g);
        logic [3:0] b;
        b[3] = g[3];
        b[2] = b[3] ^ g[2];
        b[1] = b[2] ^ g[1];
        b[0] = b[1] ^ g[0];
        return b;
    endfunction

    assign handshake  = out_valid & out_ready;
    assign can_accept = (state == EMPTY) | handshake;

    // Search upward from the requester after the last winner, wrapping; last itself is checked last.
    always_comb begin
        gnt   = 4'b0000;
        sel   = last;
        idx   = 2'd0;
        found = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            idx = last + 2'(k);
            if (!found && req[idx]) begin
                found = 1'b1;
                sel   = idx;
            end
        end
        if (rst_n && can_accept && found)
            gnt = 4'b0001 << sel;
    end

    assign sel_data  = req_data[{sel, 2'b00} +: 4];
    assign sel_mode  = req_mode[sel];
    assign conv_data = sel_mode ? gray2bin(sel_data) : bin2gray(sel_data);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= EMPTY;
            out_valid  <= 1'b0;
            out_data   <= 4'd0;
            out_id     <= 2'd0;
            out_mode   <= 1'b0;
            last       <= 2'd3;
            conv_count <= 8'd0;
        end else begin
            if (handshake)
                conv_count <= conv_count + 8'd1;
            if (|gnt) begin
                out_data <= conv_data;
                out_id   <= sel;
                out_mode <= sel_mode;
                last     <= sel;
            end
            case (state)
                EMPTY: begin
                    if (|gnt) begin
                        state     <= FULL;
                        out_valid <= 1'b1;
                    end
                end
                FULL: begin
                    if (handshake && !(|gnt)) begin
                        state     <= EMPTY;
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= EMPTY;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gray_conv_arbiter.sv
// Directed bench for gray_conv_arbiter: conversions, round-robin order, stall, mid-run reset and counter wrap.
module tb_gray_conv_arbiter;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req;
    logic [15:0] req_data;
    logic [3:0]  req_mode;
    logic [3:0]  gnt;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_data;
    logic [1:0]  out_id;
    logic        out_mode;
    logic [7:0]  conv_count;

    int n_tests = 0;
    int n_fail  = 0;

    gray_conv_arbiter dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .req_data   (req_data),
        .req_mode   (req_mode),
        .gnt        (gnt),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_id     (out_id),
        .out_mode   (out_mode),
        .conv_count (conv_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] ref_gray(input logic [3:0] v);
        return v ^ {1'b0, v[3:1]};
    endfunction

    function automatic logic [3:0] ref_bin(input logic [3:0] g);
        logic [3:0] b;
        logic       acc;
        acc = 1'b0;
        for (int i = 3; i >= 0; i--) begin
            acc  = acc ^ g[i];
            b[i] = acc;
        end
        return b;
    endfunction

    // Called at a falling edge; returns at the falling edge after capture.
    task automatic do_conv(input int idx, input logic [3:0] d, input logic m, output logic [3:0] r);
        req      = 4'(1 << idx);
        req_data = {4{d}};
        req_mode = {4{m}};
        #1 check("conv_gnt", 32'(gnt), 32'(1 << idx));
        @(posedge clk);
        #1 req = 4'b0000;
        @(negedge clk);
        check("conv_valid", 32'(out_valid), 32'd1);
        check("conv_id", 32'(out_id), 32'(idx));
        check("conv_mode", 32'(out_mode), 32'(m));
        r = out_data;
    endtask

    task automatic idle();
        req = 4'b0000;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] g, b, r;
        int n;
        rst_n     = 1'b0;
        req       = 4'b0001;
        req_data  = 16'h0000;
        req_mode  = 4'b0000;
        out_ready = 1'b1;
        #12;
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_count", 32'(conv_count), 32'd0);
        check("rst_gnt", 32'(gnt), 32'd0);
        check("rst_data", 32'(out_data), 32'd0);

        // Binary to Gray on requester 0
        @(negedge clk);
        rst_n    = 1'b1;
        req      = 4'b0001;
        req_data = 16'h000B;
        req_mode = 4'b0000;
        #1 check("t1_gnt", 32'(gnt), 32'h1);
        @(posedge clk);
        #1 req = 4'b0000;
        @(negedge clk);
        check("t1_valid", 32'(out_valid), 32'd1);
        check("t1_data", 32'(out_data), 32'hE);
        check("t1_id", 32'(out_id), 32'd0);
        check("t1_mode", 32'(out_mode), 32'd0);
        check("t1_count0", 32'(conv_count), 32'd0);
        @(posedge clk);
        @(negedge clk);
        check("t1_count1", 32'(conv_count), 32'd1);
        check("t1_empty", 32'(out_valid), 32'd0);

        // Gray to binary on requester 2
        req      = 4'b0100;
        req_data = 16'h0E00;
        req_mode = 4'b0100;
        #1 check("t2_gnt", 32'(gnt), 32'h4);
        @(posedge clk);
        #1 req = 4'b0000;
        @(negedge clk);
        check("t2_data", 32'(out_data), 32'hB);
        check("t2_id", 32'(out_id), 32'd2);
        check("t2_mode", 32'(out_mode), 32'd1);
        idle();
        check("t2_count", 32'(conv_count), 32'd2);

        // Exhaustive sweep, both directions and round trip
        for (int v = 0; v < 16; v++) begin
            do_conv(0, 4'(v), 1'b0, g);
            check("sweep_b2g", 32'(g), 32'(ref_gray(4'(v))));
            do_conv(1, 4'(v), 1'b1, b);
            check("sweep_g2b", 32'(b), 32'(ref_bin(4'(v))));
            do_conv(3, g, 1'b1, r);
            check("sweep_trip", 32'(r), 32'(v));
        end
        idle();
        check("sweep_count", 32'(conv_count), 32'd50);

        // Round-robin with all requesters held
        req      = 4'b1111;
        req_data = 16'h1234;
        req_mode = 4'b0000;
        for (int k = 0; k < 5; k++) begin
            #1 check("rr_gnt", 32'(gnt), 32'(1 << (k % 4)));
            if (k > 0)
                check("rr_id", 32'(out_id), 32'((k - 1) % 4));
            @(posedge clk);
            @(negedge clk);
        end
        check("rr_id_last", 32'(out_id), 32'd0);
        idle();
        check("rr_count", 32'(conv_count), 32'd55);

        // Backpressure: 0110 -> Gray 0101 from requester 1, held under stall
        out_ready = 1'b0;
        req       = 4'b0010;
        req_data  = 16'h0060;
        req_mode  = 4'b0000;
        #1 check("bp_gnt", 32'(gnt), 32'h2);
        @(posedge clk);
        #1 begin
            req      = 4'b1111;
            req_data = 16'h0360;
        end
        @(negedge clk);
        repeat (5) begin
            check("bp_gnt_stall", 32'(gnt), 32'd0);
            check("bp_valid", 32'(out_valid), 32'd1);
            check("bp_data", 32'(out_data), 32'h5);
            check("bp_id", 32'(out_id), 32'd1);
            @(posedge clk);
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1 check("bp_release_gnt", 32'(gnt), 32'h4);
        @(posedge clk);
        #1 req = 4'b0000;
        @(negedge clk);
        check("bp_valid_kept", 32'(out_valid), 32'd1);
        check("bp_next_id", 32'(out_id), 32'd2);
        check("bp_next_data", 32'(out_data), 32'h2);
        check("bp_count", 32'(conv_count), 32'd56);
        idle();
        check("bp_count2", 32'(conv_count), 32'd57);

        // Reset while a result is pending
        out_ready = 1'b0;
        req       = 4'b1000;
        @(posedge clk);
        @(negedge clk);
        check("mr_pending", 32'(out_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mr_valid", 32'(out_valid), 32'd0);
        check("mr_count", 32'(conv_count), 32'd0);
        check("mr_gnt", 32'(gnt), 32'd0);
        @(negedge clk);
        rst_n     = 1'b1;
        req       = 4'b1001;
        out_ready = 1'b1;
        #1 check("mr_first_gnt", 32'(gnt), 32'h1);
        @(posedge clk);
        @(negedge clk);
        check("mr_first_id", 32'(out_id), 32'd0);
        check("mr_second_gnt", 32'(gnt), 32'h8);
        @(posedge clk);
        @(negedge clk);
        check("mr_count1", 32'(conv_count), 32'd1);
        check("mr_second_id", 32'(out_id), 32'd3);

        // Counter wrap with one handshake per cycle
        req = 4'b0001;
        n   = 0;
        while (conv_count != 8'd255 && n < 300) begin
            @(posedge clk);
            @(negedge clk);
            n++;
        end
        check("wrap_255", 32'(conv_count), 32'd255);
        check("wrap_cycles", 32'(n), 32'd254);
        @(posedge clk);
        @(negedge clk);
        check("wrap_0", 32'(conv_count), 32'd0);
        check("wrap_valid", 32'(out_valid), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
